// File: rtl/stream_mux_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stream_mux_pkg
//  Description : Shared types for the stream_mux_arb arbitrated multiplexer.
//  Revision    : 1.0 - initial release
// ============================================================================
package stream_mux_pkg;

    typedef enum logic {ARB_FIXED = 1'b0, ARB_RR = 1'b1} arb_mode_e;

    typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} mux_state_e;

endpackage
`default_nettype wire

// File: rtl/stream_mux_arb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational N-way arbiter, fixed priority or round-robin
//                starting the search at ptr.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int N    = 8,
    localparam int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    input  arb_mode_e       mode,
    output logic [N-1:0]    gnt_oh,
    output logic [SELW-1:0] gnt_idx,
    output logic            any
);

    int unsigned w_start;
    int unsigned w_idx;

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        any     = 1'b0;
        w_idx   = 0;
        w_start = (mode == ARB_RR) ? 32'(ptr) : 32'd0;
        // Scan N positions from the start index, wrapping past N-1.
        for (int unsigned k = 0; k < N; k++) begin
            w_idx = w_start + k;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (!any && req[w_idx[SELW-1:0]]) begin
                any                        = 1'b1;
                gnt_idx                    = w_idx[SELW-1:0];
                gnt_oh[w_idx[SELW-1:0]]    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/stream_mux_arb.sv
`default_nettype none
// ============================================================================
//  Module      : stream_mux_arb
//  Description : N-to-1 streaming mux with valid/ready handshakes, selectable
//                arbitration, packet locking and a registered output stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_mux_arb
    import stream_mux_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 8,
    localparam int SELW  = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [N-1:0][WIDTH-1:0] in_data,
    input  logic [N-1:0]          in_valid,
    input  logic [N-1:0]          in_last,
    output logic [N-1:0]          in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic [SELW-1:0]       out_sel
);

    mux_state_e       r_state;
    mux_state_e       w_state_next;
    logic [SELW-1:0]  r_ptr;
    logic [SELW-1:0]  r_lock_idx;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_out_last;
    logic [SELW-1:0]  r_out_sel;

    logic [N-1:0]     w_arb_oh;
    logic [SELW-1:0]  w_arb_idx;
    logic             w_arb_any;
    logic             w_load;
    logic [SELW-1:0]  w_gnt_idx;
    logic             w_gnt_valid;
    logic             w_xfer;
    logic             w_xfer_last;

    rr_arbiter #(.N(N)) u_arb (
        .req     (in_valid),
        .ptr     (r_ptr),
        .mode    (arb_mode_e'(mode)),
        .gnt_oh  (w_arb_oh),
        .gnt_idx (w_arb_idx),
        .any     (w_arb_any)
    );

    assign w_load = !r_out_valid || out_ready;

    always_comb begin
        w_state_next = r_state;
        w_gnt_idx    = w_arb_idx;
        w_gnt_valid  = w_arb_any;
        // A locked packet owns the grant until its last beat, ignoring mode.
        if (r_state == ST_LOCKED) begin
            w_gnt_idx   = r_lock_idx;
            w_gnt_valid = in_valid[r_lock_idx];
        end
        w_xfer      = w_load && w_gnt_valid;
        w_xfer_last = in_last[w_gnt_idx];

        in_ready = '0;
        if (w_load && ((r_state == ST_LOCKED) || (w_arb_oh != '0))) begin
            in_ready[w_gnt_idx] = 1'b1;
        end

        case (r_state)
            ST_IDLE:   if (w_xfer && !w_xfer_last) w_state_next = ST_LOCKED;
            ST_LOCKED: if (w_xfer &&  w_xfer_last) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_lock_idx  <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_sel   <= '0;
        end else begin
            if (w_xfer && w_xfer_last) begin
                r_ptr <= (w_gnt_idx == SELW'(N - 1)) ? '0 : w_gnt_idx + 1'b1;
            end
            if ((r_state == ST_IDLE) && w_xfer && !w_xfer_last) begin
                r_lock_idx <= w_gnt_idx;
            end
            if (w_load) begin
                r_out_valid <= w_xfer;
                if (w_xfer) begin
                    r_out_data <= in_data[w_gnt_idx];
                    r_out_last <= w_xfer_last;
                    r_out_sel  <= w_gnt_idx;
                end
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_sel   = r_out_sel;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_mux_arb
//  Description : Directed scoreboard bench for stream_mux_arb.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_mux_arb;

    localparam int W  = 32;
    localparam int NC = 8;
    localparam int SW = 3;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   mode = 1'b0;
    logic [NC-1:0][W-1:0]   in_data = '0;
    logic [NC-1:0]          in_valid = '0;
    logic [NC-1:0]          in_last = '0;
    logic [NC-1:0]          in_ready;
    logic [W-1:0]           out_data;
    logic                   out_valid;
    logic                   out_last;
    logic                   out_ready = 1'b0;
    logic [SW-1:0]          out_sel;

    typedef struct {
        logic [W-1:0]  d;
        logic          l;
        logic [SW-1:0] s;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    stream_mux_arb #(.WIDTH(W), .N(NC)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .out_sel   (out_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] d, input logic l, input logic [SW-1:0] s);
        exp_t e;
        e.d = d; e.l = l; e.s = s;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        in_valid = '0;
        in_last  = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Monitor: every accepted output beat must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", {29'd0, out_sel, out_data}, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("beat_data", 64'(out_data), 64'(e.d));
                chk("beat_last", 64'(out_last), 64'(e.l));
                chk("beat_sel",  64'(out_sel),  64'(e.s));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset then idle
        do_reset();
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sel",   64'(out_sel),   64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        step();

        // Fixed priority: ch3 beats ch5 and starves it while valid
        mode = 1'b0;
        out_ready = 1'b1;
        in_data[3] = 32'h33;
        in_data[5] = 32'h55;
        in_valid = 8'h28;
        in_last  = 8'h28;
        for (int i = 0; i < 3; i++) begin
            #1 chk("fix_ready", 64'(in_ready), 64'h08);
            push(32'h33, 1'b1, 3'd3);
            step();
        end
        in_valid = 8'h20;
        #1 chk("fix_ready5", 64'(in_ready), 64'h20);
        push(32'h55, 1'b1, 3'd5);
        step();
        in_valid = '0;
        drain();

        // Round-robin fairness among 0, 2, 7
        do_reset();
        mode = 1'b1;
        out_ready = 1'b1;
        in_data[0] = 32'hA0;
        in_data[2] = 32'hA2;
        in_data[7] = 32'hA7;
        in_valid = 8'h85;
        in_last  = 8'h85;
        for (int i = 0; i < 2; i++) begin
            push(32'hA0, 1'b1, 3'd0); step(); chk("rr_tput", 64'(out_valid), 64'd1);
            push(32'hA2, 1'b1, 3'd2); step(); chk("rr_tput", 64'(out_valid), 64'd1);
            push(32'hA7, 1'b1, 3'd7); step(); chk("rr_tput", 64'(out_valid), 64'd1);
        end
        in_valid = '0;
        drain();

        // Packet lock: ch1 3-beat packet while ch4 waits
        do_reset();
        mode = 1'b1;
        out_ready = 1'b1;
        in_data[4] = 32'h444;
        in_valid = 8'h12;
        in_last  = 8'h10;
        for (int b = 0; b < 3; b++) begin
            in_data[1] = 32'h100 + 32'(b);
            if (b == 2) in_last = 8'h12;
            #1 chk("lock_ready", 64'(in_ready), 64'h02);
            push(32'h100 + 32'(b), (b == 2), 3'd1);
            if (b == 1) mode = 1'b0;
            step();
        end
        in_valid = 8'h10;
        #1 chk("lock_release", 64'(in_ready), 64'h10);
        push(32'h444, 1'b1, 3'd4);
        step();
        in_valid = '0;
        drain();

        // Back-pressure: DEADBEEF held for 4 cycles
        do_reset();
        mode = 1'b0;
        out_ready = 1'b1;
        in_data[0] = 32'hDEADBEEF;
        in_valid = 8'h01;
        in_last  = 8'h01;
        push(32'hDEADBEEF, 1'b1, 3'd0);
        step();
        out_ready = 1'b0;
        in_data[0] = 32'h12345678;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_in_ready",  64'(in_ready),  64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_out_data",  64'(out_data),  64'hDEADBEEF);
            chk("bp_out_sel",   64'(out_sel),   64'd0);
            step();
        end
        out_ready = 1'b1;
        #1 chk("bp_resume_ready", 64'(in_ready), 64'h01);
        push(32'h12345678, 1'b1, 3'd0);
        step();
        in_valid = '0;
        drain();
        step();
        chk("idle_valid_low", 64'(out_valid), 64'd0);
        chk("idle_data_hold", 64'(out_data),  64'h12345678);

        // Reset in the middle of a ch6 packet
        do_reset();
        mode = 1'b0;
        out_ready = 1'b1;
        in_data[6] = 32'h61;
        in_valid = 8'h40;
        in_last  = 8'h00;
        push(32'h61, 1'b0, 3'd6);
        step();
        in_data[6] = 32'h62;
        #1;
        rst = 1'b1;
        exp_q.delete();
        in_valid = '0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_data",  64'(out_data),  64'd0);
        chk("mid_rst_sel",   64'(out_sel),   64'd0);
        step();
        rst = 1'b0;
        in_data[2] = 32'h22;
        in_data[6] = 32'h63;
        in_valid = 8'h44;
        in_last  = 8'h04;
        #1 chk("post_rst_ready", 64'(in_ready), 64'h04);
        push(32'h22, 1'b1, 3'd2);
        step();
        in_valid = '0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
